bin_to_bcd_converter: RTL and testbench

- Sequential double-dabble (shift-add-3) converter from the multiplier's binary product to packed BCD.
- Sits directly upstream of display_multiplexer and drives its BCD_code input.
- Output packing matches the multiplexer exactly: thousands in [27:24], hundreds [23:20], tens [19:16], units [15:12], [11:0] zero.
- Result is held stable between conversions so the display never shows intermediate values.

---
 rtl/bin_to_bcd_converter_if.sv | 22 ++
 rtl/bin_to_bcd_converter.sv | 98 +++++++++
 tb/tb_bin_to_bcd_converter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/bin_to_bcd_converter_if.sv
// Handshake and result bus between the binary source, the BCD converter and the display.
// The master side requests conversions and the slave side (the converter) returns packed BCD.
interface bin_to_bcd_converter_if #(
    parameter int DATA_WIDTH = 14
);
    logic                  start;
    logic [DATA_WIDTH-1:0] binary_in;
    logic                  busy;
    logic                  done;
    logic                  overflow;
    logic [27:0]           BCD_code;

    modport master (
        output start, binary_in,
        input  busy, done, overflow, BCD_code
    );

    modport slave (
        input  start, binary_in,
        output busy, done, overflow, BCD_code
    );
endinterface

// File: rtl/bin_to_bcd_converter.sv
// Sequential double-dabble converter: binary product -> four packed BCD digits for the display mux.
// The result is held between conversions and saturates to 9999 when the input exceeds it.
module bin_to_bcd_converter #(
    parameter int DATA_WIDTH = 14
) (
    input logic                  clk,
    input logic                  reset,
    bin_to_bcd_converter_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [15:0]           scratch_q, scratch_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ovf_pend_q, ovf_pend_d;
    logic [27:0]           bcd_q, bcd_d;
    logic                  ovf_q, ovf_d;
    logic                  done_q, done_d;
    logic [15:0]           adj;

    // Pre-shift correction: any digit >= 5 would become >= 10 after doubling.
    function automatic logic [15:0] add3(input logic [15:0] s);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = (s[i*4 +: 4] >= 4'd5) ? s[i*4 +: 4] + 4'd3 : s[i*4 +: 4];
        end
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        adj        = add3(scratch_q);
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    shift_d    = bus.binary_in;
                    scratch_d  = 16'h0000;
                    cnt_d      = '0;
                    ovf_pend_d = ({{(32-DATA_WIDTH){1'b0}}, bus.binary_in} > 32'd9999);
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == CNT_W'(DATA_WIDTH)) begin
                    state_d = LOAD;
                end else begin
                    // The scratch MSB falls off the top; only values <= 9999 are ever published.
                    {scratch_d, shift_d} = {adj[14:0], shift_q, 1'b0};
                    cnt_d                = cnt_q + CNT_W'(1);
                end
            end
            LOAD: begin
                bcd_d   = ovf_pend_q ? 28'h9999000 : {scratch_q, 12'h000};
                ovf_d   = ovf_pend_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            scratch_q  <= 16'h0000;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= 28'h0000000;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.overflow = ovf_q;
    assign bus.BCD_code = bcd_q;
endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Directed bench for bin_to_bcd_converter: latency, hold, saturation, ignored start and abort by reset.
module tb_bin_to_bcd_converter;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    bin_to_bcd_converter_if #(.DATA_WIDTH(14)) bus ();

    bin_to_bcd_converter #(.DATA_WIDTH(14)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts a conversion from the current point (between edges) and checks every cycle up to done.
    // Returns one time unit after the done edge, i.e. inside the done cycle.
    task automatic run_conv(input logic [13:0] v, input logic [27:0] exp_bcd,
                            input logic exp_ovf, input bit inject, input string name);
        logic [27:0] prev_bcd;
        logic        prev_ovf;
        bus.start     = 1'b1;
        bus.binary_in = v;
        @(posedge clk); #1;
        bus.start = 1'b0;
        prev_bcd  = bus.BCD_code;
        prev_ovf  = bus.overflow;
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL %s edge0: busy=%b done=%b, need busy=1 done=0", name, bus.busy, bus.done);
        end
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            if (inject && k == 4) begin
                bus.start     = 1'b1;
                bus.binary_in = 14'd77;
            end
            if (inject && k == 5) begin
                bus.start = 1'b0;
            end
            checks++;
            if (k < 16) begin
                if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.BCD_code !== prev_bcd
                    || bus.overflow !== prev_ovf) begin
                    errors++;
                    $display("FAIL %s edge%0d: busy=%b done=%b bcd=%h ovf=%b, need 1 0 %h %b",
                             name, k, bus.busy, bus.done, bus.BCD_code, bus.overflow,
                             prev_bcd, prev_ovf);
                end
            end else begin
                if (bus.busy !== 1'b0 || bus.done !== 1'b1 || bus.BCD_code !== exp_bcd
                    || bus.overflow !== exp_ovf) begin
                    errors++;
                    $display("FAIL %s result: busy=%b done=%b bcd=%h ovf=%b, need 0 1 %h %b",
                             name, bus.busy, bus.done, bus.BCD_code, bus.overflow,
                             exp_bcd, exp_ovf);
                end
            end
        end
        bus.binary_in = 14'd0;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.binary_in = 14'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.overflow !== 1'b0
            || bus.BCD_code !== 28'h0000000) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b ovf=%b bcd=%h, need 0 0 0 0000000",
                     bus.busy, bus.done, bus.overflow, bus.BCD_code);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b done=%b, need 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_basic();
        run_conv(14'd1234, 28'h1234000, 1'b0, 1'b0, "conv_1234");
        @(posedge clk); #1;
        checks++;
        if (bus.done !== 1'b0 || bus.BCD_code !== 28'h1234000) begin
            errors++;
            $display("FAIL done_single_cycle: done=%b bcd=%h, need 0 1234000", bus.done, bus.BCD_code);
        end
        run_conv(14'd786, 28'h0786000, 1'b0, 1'b0, "conv_786");
        checks++;
        if (bus.BCD_code[27:24] !== 4'd0 || bus.BCD_code[23:20] !== 4'd7
            || bus.BCD_code[19:16] !== 4'd8 || bus.BCD_code[15:12] !== 4'd6
            || bus.BCD_code[11:0] !== 12'h000) begin
            errors++;
            $display("FAIL digits_786: got %h, need digits 0,7,8,6 and low 000", bus.BCD_code);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        run_conv(14'd0, 28'h0000000, 1'b0, 1'b0, "conv_0");
        run_conv(14'd9999, 28'h9999000, 1'b0, 1'b0, "conv_9999_b2b");
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        run_conv(14'd12000, 28'h9999000, 1'b1, 1'b0, "conv_12000_sat");
        @(posedge clk); #1;
        run_conv(14'd5, 28'h0005000, 1'b0, 1'b0, "conv_5_after_ovf");
        @(posedge clk); #1;
        run_conv(14'd10000, 28'h9999000, 1'b1, 1'b0, "conv_10000_sat");
        @(posedge clk); #1;
        run_conv(14'd16383, 28'h9999000, 1'b1, 1'b0, "conv_16383_sat");
        @(posedge clk); #1;
    endtask

    task automatic test_ignored_start();
        run_conv(14'd42, 28'h0042000, 1'b0, 1'b1, "conv_42_ignore");
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.BCD_code !== 28'h0042000) begin
                errors++;
                $display("FAIL ignored_start_c%0d: done=%b busy=%b bcd=%h, need 0 0 0042000",
                         k, bus.done, bus.busy, bus.BCD_code);
            end
        end
    endtask

    task automatic test_reset_abort();
        run_conv(14'd12000, 28'h9999000, 1'b1, 1'b0, "conv_pre_abort");
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.binary_in = 14'd4321;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.overflow !== 1'b0
            || bus.BCD_code !== 28'h0000000) begin
            errors++;
            $display("FAIL async_reset_abort: busy=%b done=%b ovf=%b bcd=%h, need 0 0 0 0000000",
                     bus.busy, bus.done, bus.overflow, bus.BCD_code);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.BCD_code !== 28'h0000000) begin
                errors++;
                $display("FAIL no_done_after_abort_c%0d: done=%b busy=%b bcd=%h, need 0 0 0000000",
                         k, bus.done, bus.busy, bus.BCD_code);
            end
        end
        run_conv(14'd8, 28'h0008000, 1'b0, 1'b0, "conv_8_after_reset");
        @(posedge clk); #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_ignored_start();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
